// File: rtl/proto_clone_pkg.sv
// Shared types and default sizes for the prototype clone scheduler.
// Optional parity protection of stored template words is enabled by
// defining PROTO_CLONE_PARITY_EN (see proto_clone_sched).
package proto_clone_pkg;

    localparam int NUM_REQ_D   = 4;
    localparam int NUM_PROTO_D = 8;
    localparam int WORDS_D     = 4;
    localparam int DATA_W_D    = 32;
    localparam int ID_W_D      = $clog2(NUM_PROTO_D);

    typedef enum logic {IDLE, COPY} clone_state_e;

    typedef logic [ID_W_D-1:0] proto_id_t;

endpackage

// File: rtl/proto_clone_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the
// pointer and moves the pointer one past the winner when told to advance.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int RQ_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [RQ_W-1:0]    idx,
    output logic               any
);

    logic [RQ_W-1:0] ptr;

    // Search requests starting at the pointer, wrapping around once.
    always_comb begin
        int k;
        k     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = RQ_W'(k);
            end
        end
    end

    // Pointer moves to the requester after the one just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/proto_clone_sched.sv
// Prototype clone scheduler: a table of template records loaded over a
// config port, and one clone engine shared by several requesters through
// round-robin arbitration. A granted clone streams WORDS words on a
// valid/ready bus tagged with the owning requester.
// Define PROTO_CLONE_PARITY_EN to store an even-parity bit per word and
// expose the sticky par_err flag.
module proto_clone_sched
    import proto_clone_pkg::*;
#(
    parameter  int NUM_REQ   = NUM_REQ_D,
    parameter  int NUM_PROTO = NUM_PROTO_D,
    parameter  int WORDS     = WORDS_D,
    parameter  int DATA_W    = DATA_W_D,
    localparam int ID_W      = $clog2(NUM_PROTO),
    localparam int WI_W      = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int RQ_W      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [ID_W-1:0]         cfg_id,
    input  logic [WI_W-1:0]         cfg_word,
    input  logic [DATA_W-1:0]       cfg_wdata,
    output logic                    cfg_ready,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*ID_W-1:0] req_id,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic [RQ_W-1:0]         out_dest,
    output logic                    busy
`ifdef PROTO_CLONE_PARITY_EN
    ,
    output logic                    par_err
`endif
);

    clone_state_e        state;
    logic [ID_W-1:0]     id_q;
    logic [RQ_W-1:0]     dest_q;
    logic [WI_W-1:0]     idx_q;
    logic [DATA_W-1:0]   tbl [NUM_PROTO][WORDS];

    logic [NUM_REQ-1:0]  grant;
    logic [RQ_W-1:0]     gidx;
    logic                gany;
    logic                in_idle;
    logic                at_last;
    logic                wr_en;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (in_idle),
        .grant   (grant),
        .idx     (gidx),
        .any     (gany)
    );

    assign in_idle   = (state == IDLE);
    assign busy      = (state == COPY);
    assign at_last   = (idx_q == WI_W'(WORDS - 1));
    // Only the template currently being copied is locked against writes.
    assign cfg_ready = !(busy && (cfg_id == id_q));
    assign wr_en     = cfg_we && cfg_ready && (int'(cfg_word) < WORDS);
    // Grants are only offered in IDLE; reset blanks them immediately.
    assign req_ready = (in_idle && rst_n) ? grant : '0;
    assign out_valid = busy;
    assign out_last  = busy && at_last;
    assign out_dest  = dest_q;
    // Read straight from the table so a write landing on the grant edge is seen.
    assign out_data  = busy ? tbl[id_q][idx_q] : '0;

    // Clone FSM: arbitrate in IDLE, walk the template words in COPY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            id_q   <= '0;
            dest_q <= '0;
            idx_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gany) begin
                        id_q   <= req_id[int'(gidx)*ID_W +: ID_W];
                        dest_q <= gidx;
                        idx_q  <= '0;
                        state  <= COPY;
                    end
                end
                COPY: begin
                    if (out_ready) begin
                        if (at_last) begin
                            state <= IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Template storage, cleared on reset and written from the config port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PROTO; p++) begin
                for (int w = 0; w < WORDS; w++) begin
                    tbl[p][w] <= '0;
                end
            end
        end else if (wr_en) begin
            tbl[cfg_id][cfg_word] <= cfg_wdata;
        end
    end

`ifdef PROTO_CLONE_PARITY_EN
    logic tbl_par [NUM_PROTO][WORDS];

    function automatic logic even_par(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction

    // Parity bit stored alongside each template word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PROTO; p++) begin
                for (int w = 0; w < WORDS; w++) begin
                    tbl_par[p][w] <= 1'b0;
                end
            end
        end else if (wr_en) begin
            tbl_par[cfg_id][cfg_word] <= even_par(cfg_wdata);
        end
    end

    // Sticky error flag on any emitted word whose parity does not match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (busy && out_ready &&
                     (even_par(out_data) != tbl_par[id_q][idx_q])) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_proto_clone_sched.sv
// Directed bench for proto_clone_sched with default parameters.
module tb_proto_clone_sched;

    localparam int NR = 4;
    localparam int IW = 3;

    logic          clk;
    logic          rst_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_id;
    logic [1:0]    cfg_word;
    logic [31:0]   cfg_wdata;
    logic          cfg_ready;
    logic [NR-1:0] req_valid;
    logic [NR*IW-1:0] req_id;
    logic [NR-1:0] req_ready;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic [1:0]    out_dest;
    logic          busy;
`ifdef PROTO_CLONE_PARITY_EN
    logic          par_err;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [8][4];

    proto_clone_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_id    (cfg_id),
        .cfg_word  (cfg_word),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
        .req_valid (req_valid),
        .req_id    (req_id),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_dest  (out_dest),
        .busy      (busy)
`ifdef PROTO_CLONE_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int id, input int w, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_id    = IW'(id);
        cfg_word  = 2'(w);
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        mdl[id][w] = d;
    endtask

    task automatic set_id(input int g, input int id);
        req_id[g*IW +: IW] = IW'(id);
    endtask

    // Expect the grant vector now, take the grant edge, then expect COPY.
    task automatic do_grant(input logic [NR-1:0] exp_gnt, input string tag);
        #1;
        chk({tag, "_gnt"}, 64'(req_ready), 64'(exp_gnt));
        tick();
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_gnt_off"}, 64'(req_ready), 64'd0);
    endtask

    // Consume one clone; mode 1 stalls with out_ready pattern 1,0,0,1,0,0...
    task automatic collect(input int dest, input int id, input int mode, input string tag);
        int beat;
        int cyc;
        beat = 0;
        cyc  = 0;
        while (beat < 4 && cyc < 40) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            #1;
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_data"}, 64'(out_data), 64'(mdl[id][beat]));
            chk({tag, "_last"}, 64'(out_last), 64'(beat == 3));
            chk({tag, "_dest"}, 64'(out_dest), 64'(dest));
            if (out_ready) beat++;
            cyc++;
            tick();
        end
        chk({tag, "_beats"}, 64'(beat), 64'd4);
        out_ready = 1'b0;
        #1;
        chk({tag, "_done_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_done_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        for (int p = 0; p < 8; p++)
            for (int w = 0; w < 4; w++)
                mdl[p][w] = 32'h0;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_id    = '0;
        cfg_word  = '0;
        cfg_wdata = '0;
        req_valid = '0;
        req_id    = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_dest", 64'(out_dest), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Load templates
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 4; w++)
                cfg_write(s, w, 32'h100 * (s + 1) + 32'(w));
        for (int w = 0; w < 4; w++) cfg_write(3, w, 32'hA0 + 32'(w));
        for (int w = 0; w < 4; w++) cfg_write(5, w, 32'h50 + 32'(w));

        // All four requesters at once; requester 0 keeps requesting
        for (int g = 0; g < NR; g++) set_id(g, g);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            do_grant(4'(1 << (k % 4)), $sformatf("rr%0d", k));
            if (k % 4 != 0) req_valid[k % 4] = 1'b0;
            if (k == 4) req_valid = '0;
            collect(k % 4, k % 4, 0, $sformatf("rr%0d", k));
        end

        // Single request on slot 3
        set_id(0, 3);
        req_valid = 4'b0001;
        do_grant(4'b0001, "t1");
        req_valid = '0;
        collect(0, 3, 0, "t1");

        // Stalled output stream
        set_id(1, 3);
        req_valid = 4'b0010;
        do_grant(4'b0010, "stall");
        req_valid = '0;
        collect(1, 3, 1, "stall");

        // Config lock on the slot being cloned, slot 5 stays writable
        set_id(2, 3);
        req_valid = 4'b0100;
        do_grant(4'b0100, "lock");
        req_valid = '0;
        cfg_we = 1'b1; cfg_id = 3'd3; cfg_word = 2'd0; cfg_wdata = 32'hBAD;
        #1;
        chk("lock_cfg_ready_same", 64'(cfg_ready), 64'd0);
        tick();
        cfg_id = 3'd5; cfg_word = 2'd0; cfg_wdata = 32'h55;
        #1;
        chk("lock_cfg_ready_other", 64'(cfg_ready), 64'd1);
        tick();
        cfg_we = 1'b0;
        mdl[5][0] = 32'h55;
        collect(2, 3, 0, "lock");
        cfg_id = 3'd3;
        #1;
        chk("lock_cfg_ready_after", 64'(cfg_ready), 64'd1);

        set_id(1, 5);
        req_valid = 4'b0010;
        do_grant(4'b0010, "rd5");
        req_valid = '0;
        collect(1, 5, 0, "rd5");

        // Write and grant to the same slot on the same edge
        set_id(3, 5);
        req_valid = 4'b1000;
        cfg_we = 1'b1; cfg_id = 3'd5; cfg_word = 2'd1; cfg_wdata = 32'h77;
        #1;
        chk("same_edge_cfg_ready", 64'(cfg_ready), 64'd1);
        mdl[5][1] = 32'h77;
        do_grant(4'b1000, "same_edge");
        cfg_we = 1'b0;
        req_valid = '0;
        collect(3, 5, 0, "same_edge");

        // Reset in the middle of a clone
        set_id(1, 3);
        req_valid = 4'b0010;
        do_grant(4'b0010, "mid");
        out_ready = 1'b1;
        tick();
        tick();
        chk("mid_beat2_data", 64'(out_data), 64'hA2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        for (int p = 0; p < 8; p++)
            for (int w = 0; w < 4; w++)
                mdl[p][w] = 32'h0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int g = 0; g < NR; g++) set_id(g, 3);
        req_valid = 4'b1111;
        do_grant(4'b0001, "post_rst");
        req_valid = '0;
        collect(0, 3, 0, "post_rst");

`ifdef PROTO_CLONE_PARITY_EN
        // Corrupt a stored bit and watch the sticky flag
        for (int w = 0; w < 4; w++) cfg_write(6, w, 32'h60 + 32'(w));
        dut.tbl[6][1] = dut.tbl[6][1] ^ 32'h1;
        mdl[6][1] = mdl[6][1] ^ 32'h1;
        chk("par_before", 64'(par_err), 64'd0);
        set_id(0, 6);
        req_valid = 4'b0001;
        do_grant(4'b0001, "par");
        req_valid = '0;
        out_ready = 1'b1;
        tick();
        chk("par_beat0", 64'(par_err), 64'd0);
        tick();
        chk("par_beat1", 64'(par_err), 64'd1);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        chk("par_sticky", 64'(par_err), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("par_rst", 64'(par_err), 64'd0);
        rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
